// File: rtl/maze_pkg.sv
// Shared definitions for the MazeRunner command link: assembler states,
// acknowledge codes and default UART timing.
package maze_pkg;

    // Command assembler: waiting for the high byte, or holding it while
    // waiting for the low byte.
    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_t;

    // Acknowledge bytes returned to the remote.
    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NEG_ACK = 8'h5A;

    // 50 MHz clock, 19200 baud.
    localparam int DEFAULT_BAUD_DIV     = 2604;
    // Gap allowed between the two bytes of a command before resync.
    localparam int DEFAULT_BYTE_TIMEOUT = 1 << 20;

endpackage

// File: rtl/uart_trx.sv
// Byte-level 8N1 UART: receiver with two-flop synchronizer and mid-bit
// sampling, plus an independent transmitter. Full duplex.
module uart_trx
    import maze_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    input  logic       i_trmt,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_rx_rdy,
    output logic [7:0] o_rx_data,
    output logic       o_rx_busy
);

    localparam int            CW   = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    logic          r_rx_busy, r_rx_rdy;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_data;

    logic          r_tx, r_tx_busy;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic [8:0]    r_tx_shift;

    logic w_rx_fall, w_rx_tick, w_tx_tick, w_tx_done;

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_tx_tick = (r_tx_cnt == '0);
    // Combinational so the owner can flag completion on the very edge
    // that ends the stop bit.
    assign w_tx_done = r_tx_busy & w_tx_tick & (r_tx_bit == 4'd9);

    assign o_tx      = r_tx;
    assign o_tx_busy = r_tx_busy;
    assign o_tx_done = w_tx_done;
    assign o_rx_rdy  = r_rx_rdy;
    assign o_rx_data = r_rx_data;
    assign o_rx_busy = r_rx_busy;

    // Metastability synchronizer plus one delayed copy for edge detect;
    // resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= i_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // Receiver: half-bit delay to the start-bit centre, then one sample per
    // bit; start re-checked (glitch reject), stop checked (framing).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_busy <= 1'b0;
            r_rx_rdy  <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_bit  <= 4'd0;
            r_rx_data <= 8'h00;
        end else begin
            r_rx_rdy <= 1'b0;
            if (!r_rx_busy) begin
                if (w_rx_fall) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= HALF;
                    r_rx_bit  <= 4'd0;
                end
            end else if (w_rx_tick) begin
                r_rx_cnt <= FULL;
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_s2) r_rx_busy <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0;
                    r_rx_rdy  <= r_rx_s2;
                end else begin
                    r_rx_data <= {r_rx_s2, r_rx_data[7:1]};
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end
        end
    end

    // Transmitter: start bit driven on the accepting edge, then data LSB
    // first and the stop bit, each held BAUD_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 4'd0;
            r_tx_shift <= 9'h1FF;
        end else if (!r_tx_busy) begin
            if (i_trmt) begin
                r_tx_busy  <= 1'b1;
                r_tx       <= 1'b0;
                r_tx_shift <= {1'b1, i_tx_data};
                r_tx_cnt   <= FULL;
                r_tx_bit   <= 4'd0;
            end
        end else if (w_tx_tick) begin
            r_tx_cnt <= FULL;
            if (r_tx_bit == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_tx      <= 1'b1;
            end else begin
                r_tx       <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_bit   <= r_tx_bit + 4'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Command link endpoint: pairs received bytes (high first) into 16-bit
// commands with a ready flag, and sends one-byte acknowledges.
module uart_cmd_wrapper
    import maze_pkg::*;
#(
    parameter int BAUD_DIV     = DEFAULT_BAUD_DIV,
    parameter int BYTE_TIMEOUT = DEFAULT_BYTE_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rx,
    output logic        o_tx,
    output logic [15:0] o_cmd,
    output logic        o_cmd_rdy,
    input  logic        i_clr_cmd_rdy,
    input  logic        i_send_resp,
    input  logic [7:0]  i_resp,
    output logic        o_resp_sent
);

    localparam int              TO_W   = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(BYTE_TIMEOUT);

    asm_state_t      r_state;
    logic [7:0]      r_hi;
    logic [15:0]     r_cmd;
    logic            r_cmd_rdy;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_resp_sent;

    logic       w_rx_rdy, w_rx_busy, w_tx_busy, w_tx_done;
    logic [7:0] w_rx_data;

    uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx      (i_rx),
        .i_trmt    (i_send_resp),
        .i_tx_data (i_resp),
        .o_tx      (o_tx),
        .o_tx_busy (w_tx_busy),
        .o_tx_done (w_tx_done),
        .o_rx_rdy  (w_rx_rdy),
        .o_rx_data (w_rx_data),
        .o_rx_busy (w_rx_busy)
    );

    assign o_cmd       = r_cmd;
    assign o_cmd_rdy   = r_cmd_rdy;
    assign o_resp_sent = r_resp_sent;

    // Byte-pair assembler; a completed command's set of cmd_rdy is written
    // last so it overrides a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= WAIT_HI;
            r_hi      <= 8'h00;
            r_cmd     <= 16'h0000;
            r_cmd_rdy <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (i_clr_cmd_rdy) r_cmd_rdy <= 1'b0;
            case (r_state)
                WAIT_HI: begin
                    r_to_cnt <= '0;
                    if (w_rx_rdy) begin
                        r_hi      <= w_rx_data;
                        r_cmd_rdy <= 1'b0;
                        r_state   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (w_rx_rdy) begin
                        r_cmd     <= {r_hi, w_rx_data};
                        r_cmd_rdy <= 1'b1;
                        r_to_cnt  <= '0;
                        r_state   <= WAIT_HI;
                    end else if (w_rx_busy) begin
                        // Only idle line time counts toward the resync.
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == TO_MAX) begin
                        r_hi     <= 8'h00;
                        r_to_cnt <= '0;
                        r_state  <= WAIT_HI;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= WAIT_HI;
            endcase
        end
    end

    // resp_sent: cleared when a new acknowledge is accepted, set when its
    // stop bit completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_sent <= 1'b0;
        end else if (i_send_resp && !w_tx_busy) begin
            r_resp_sent <= 1'b0;
        end else if (w_tx_done) begin
            r_resp_sent <= 1'b1;
        end
    end

endmodule
